// File: rtl/sec_scrub_ctrl.sv
// Memory scrubber: reads each word, passes it through an external SEC corrector and
// writes back corrected data words. Defining SCRUB_ABORT_EN adds an abort input.
module sec_scrub_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int LAST_ADDR = 255,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
`ifdef SCRUB_ABORT_EN
    input  logic              abort,
`endif
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [39:0]       mem_rdata,
    output logic [31:0]       mem_wdata,
    output logic [31:0]       sec_id,
    output logic [7:0]        sec_ic,
    output logic              sec_r,
    input  logic [31:0]       sec_od,
    output logic [CNT_W-1:0]  corr_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        CHECK,
        WR_REQ,
        NEXT,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(LAST_ADDR);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    state_t      state;
    logic [31:0] data_q;
    logic [7:0]  chk_q;
    logic        abort_req;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

`ifdef SCRUB_ABORT_EN
    assign abort_req = abort && (state != IDLE);
`else
    assign abort_req = 1'b0;
`endif

    assign sec_id = data_q;
    assign sec_ic = chk_q;

    // Outputs are registered, so each transition also sets the strobes of the state it enters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            sec_r     <= 1'b0;
            mem_addr  <= '0;
            corr_cnt  <= '0;
            mem_wdata <= '0;
            data_q    <= '0;
            chk_q     <= '0;
        end else if (abort_req) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            sec_r  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RD_REQ;
                        mem_addr <= '0;
                        corr_cnt <= '0;
                        busy     <= 1'b1;
                        mem_rd   <= 1'b1;
                    end
                end
                RD_REQ: begin
                    if (mem_ready) begin
                        mem_rd <= 1'b0;
                        state  <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (mem_rvalid) begin
                        data_q <= mem_rdata[31:0];
                        chk_q  <= mem_rdata[39:32];
                        sec_r  <= 1'b1;
                        state  <= CHECK;
                    end
                end
                CHECK: begin
                    sec_r <= 1'b0;
                    // Only the data word is rewritten; check bits stay as stored.
                    if (sec_od != data_q) begin
                        mem_wdata <= sec_od;
                        corr_cnt  <= sat_inc(corr_cnt);
                        mem_wr    <= 1'b1;
                        state     <= WR_REQ;
                    end else begin
                        state <= NEXT;
                    end
                end
                WR_REQ: begin
                    if (mem_ready) begin
                        mem_wr <= 1'b0;
                        state  <= NEXT;
                    end
                end
                NEXT: begin
                    if (mem_addr == LAST) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        mem_addr <= mem_addr + ADDR_W'(1);
                        mem_rd   <= 1'b1;
                        state    <= RD_REQ;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                    sec_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sec_scrub_ctrl.sv
// Scoreboard bench for sec_scrub_ctrl: random memory responder, Hamming-style SEC model,
// expected reads/writes/done values queued by the stimulus and checked by a monitor.
`timescale 1ns/1ps
module tb_sec_scrub_ctrl;
    localparam int ADDR_W    = 8;
    localparam int LAST_ADDR = 3;
    localparam int CNT_W     = 2;
    localparam int NW        = LAST_ADDR + 1;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              busy, done, mem_rd, mem_wr, sec_r;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready = 1'b0;
    logic              mem_rvalid = 1'b0;
    logic [39:0]       mem_rdata = '0;
    logic [31:0]       mem_wdata, sec_id, sec_od;
    logic [7:0]        sec_ic;
    logic [CNT_W-1:0]  corr_cnt;
`ifdef SCRUB_ABORT_EN
    logic              abort = 1'b0;
`endif

    sec_scrub_ctrl #(.ADDR_W(ADDR_W), .LAST_ADDR(LAST_ADDR), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
`ifdef SCRUB_ABORT_EN
        .abort(abort),
`endif
        .start(start), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .mem_wdata(mem_wdata), .sec_id(sec_id), .sec_ic(sec_ic), .sec_r(sec_r),
        .sec_od(sec_od), .corr_cnt(corr_cnt)
    );

    always #5 clk = ~clk;

    // Check bits: XOR of (bit index + 1) over all set data bits, so one flipped bit
    // yields a syndrome equal to its position.
    function automatic logic [7:0] calc_chk(input logic [31:0] d);
        logic [7:0] s;
        s = '0;
        for (int i = 0; i < 32; i++) if (d[i]) s ^= 8'(i + 1);
        return s;
    endfunction

    function automatic logic [31:0] sec_fix(input logic [31:0] d, input logic [7:0] c);
        logic [7:0]  syn;
        logic [31:0] r;
        syn = calc_chk(d) ^ c;
        r = d;
        if (syn != 0 && syn <= 32) r[int'(syn) - 1] = ~r[int'(syn) - 1];
        return r;
    endfunction

    assign sec_od = sec_r ? sec_fix(sec_id, sec_ic) : sec_id;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    logic [ADDR_W-1:0] rd_q[$];
    wr_t               wr_q[$];
    logic [CNT_W-1:0]  done_q[$];

    logic [31:0] orig     [NW];
    logic [31:0] mem_data [NW];
    logic [7:0]  mem_chk  [NW];

    int total = 0;
    int bad   = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: three stall cycles per request
    int rv_min = 0;
    int rv_max = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Memory responder: decides ready each cycle and returns read data after a random delay.
    bit rd_pend = 0;
    int rd_dly = 0;
    int rd_a = 0;
    int stall_n = 0;
    always @(negedge clk) begin
        if (rst) begin
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            rd_pend    = 0;
            stall_n    = 0;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = {8'($urandom), 32'($urandom)};
            if (rd_pend) begin
                if (rd_dly == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = {mem_chk[rd_a], mem_data[rd_a]};
                    rd_pend    = 0;
                end else begin
                    rd_dly--;
                end
            end
            if (mem_rd || mem_wr) begin
                case (rdy_mode)
                    0: mem_ready = 1'b1;
                    1: mem_ready = ($urandom_range(0, 2) != 0);
                    default: begin
                        if (stall_n < 3) begin
                            mem_ready = 1'b0;
                            stall_n++;
                        end else begin
                            mem_ready = 1'b1;
                        end
                    end
                endcase
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            if (mem_rd && mem_ready) begin
                rd_pend = 1;
                rd_a    = int'(mem_addr);
                rd_dly  = $urandom_range(rv_min, rv_max);
                stall_n = 0;
            end
            if (mem_wr && mem_ready) begin
                mem_data[int'(mem_addr)] = mem_wdata;
                stall_n = 0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT completes a handshake or signals done.
    logic              prev_rd_stall = 0, prev_wr_stall = 0, prev_done = 0;
    logic [ADDR_W-1:0] prev_addr = '0;
    always @(negedge clk) begin
        #1;
        if (rst) begin
            prev_rd_stall = 0;
            prev_wr_stall = 0;
            prev_done     = 0;
        end else begin
            check("rd_wr_exclusive", 64'(mem_rd & mem_wr), 0);
            if (prev_rd_stall) begin
                check("rd_held_during_stall", 64'(mem_rd), 1);
                check("rd_addr_stable", 64'(mem_addr), 64'(prev_addr));
            end
            if (prev_wr_stall) begin
                check("wr_held_during_stall", 64'(mem_wr), 1);
                check("wr_addr_stable", 64'(mem_addr), 64'(prev_addr));
            end
            if (prev_done) begin
                check("done_single_cycle", 64'(done), 0);
                check("busy_low_after_done", 64'(busy), 0);
            end
            if (mem_rd && mem_ready) begin
                check("read_expected", 64'(rd_q.size() != 0), 1);
                if (rd_q.size() != 0) check("read_addr", 64'(mem_addr), 64'(rd_q.pop_front()));
            end
            if (mem_wr && mem_ready) begin
                check("write_expected", 64'(wr_q.size() != 0), 1);
                if (wr_q.size() != 0) begin
                    wr_t w;
                    w = wr_q.pop_front();
                    check("write_addr", 64'(mem_addr), 64'(w.a));
                    check("write_data", 64'(mem_wdata), 64'(w.d));
                end
            end
            if (done) begin
                check("done_expected", 64'(done_q.size() != 0), 1);
                check("busy_during_done", 64'(busy), 1);
                if (done_q.size() != 0) check("corr_cnt_at_done", 64'(corr_cnt), 64'(done_q.pop_front()));
            end
            prev_rd_stall = mem_rd && !mem_ready;
            prev_wr_stall = mem_wr && !mem_ready;
            prev_addr     = mem_addr;
            prev_done     = done;
        end
    end

    task automatic load_mem(input logic [NW-1:0] flips, input int fbit);
        for (int i = 0; i < NW; i++) begin
            orig[i]     = $urandom;
            mem_chk[i]  = calc_chk(orig[i]);
            mem_data[i] = orig[i];
            if (flips[i]) begin
                int b;
                b = (fbit < 0) ? $urandom_range(0, 31) : fbit;
                mem_data[i][b] = ~mem_data[i][b];
            end
        end
    endtask

    // Reference: every word read once in order; each corrupted word written back with
    // its original value; count of corrected words saturates at CNT_MAX.
    task automatic expect_pass(input logic [NW-1:0] flips);
        int n;
        n = 0;
        for (int i = 0; i < NW; i++) begin
            rd_q.push_back(ADDR_W'(i));
            if (flips[i]) begin
                wr_q.push_back('{a: ADDR_W'(i), d: orig[i]});
                n++;
            end
        end
        done_q.push_back(CNT_W'((n > CNT_MAX) ? CNT_MAX : n));
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("pass_ends_in_budget", 64'(busy), 0);
        @(negedge clk);
        check("reads_all_seen", 64'(rd_q.size()), 0);
        check("writes_all_seen", 64'(wr_q.size()), 0);
        check("done_seen", 64'(done_q.size()), 0);
    endtask

    task automatic timed_pass(input logic [NW-1:0] flips, input int fbit, input int exp_lat);
        int cyc;
        load_mem(flips, fbit);
        expect_pass(flips);
        pulse_start();
        cyc = 0;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("done_latency", 64'(cyc), 64'(exp_lat));
        wait_idle();
    endtask

    task automatic scrub_pass(input logic [NW-1:0] flips);
        load_mem(flips, -1);
        expect_pass(flips);
        pulse_start();
        wait_idle();
    endtask

    task automatic check_reset_vals();
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_mem_rd", 64'(mem_rd), 0);
        check("rst_mem_wr", 64'(mem_wr), 0);
        check("rst_sec_r", 64'(sec_r), 0);
        check("rst_mem_addr", 64'(mem_addr), 0);
        check("rst_corr_cnt", 64'(corr_cnt), 0);
        check("rst_mem_wdata", 64'(mem_wdata), 0);
        check("rst_sec_id", 64'(sec_id), 0);
        check("rst_sec_ic", 64'(sec_ic), 0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_without_start", 64'(busy), 0);

        // Clean pass and a single correction with an always-ready memory.
        rdy_mode = 0; rv_min = 0; rv_max = 0;
        timed_pass('0, -1, 16);
        check("corr_cnt_clean_hold", 64'(corr_cnt), 0);
        timed_pass(4'b0100, 5, 17);
        check("corr_cnt_one_hold", 64'(corr_cnt), 1);

        // Three-cycle stalls on every read and write request.
        rdy_mode = 2;
        scrub_pass(4'b0101);

        // Start pulsed mid-pass must not restart or clear the count.
        rdy_mode = 1; rv_min = 0; rv_max = 2;
        load_mem(4'b0001, -1);
        expect_pass(4'b0001);
        pulse_start();
        n = 0;
        while (mem_addr != 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reached_addr1", 64'(mem_addr), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        check("corr_cnt_not_cleared", 64'(corr_cnt), 1);

        // Counter saturation with every word corrupted.
        scrub_pass(4'b1111);
        check("corr_cnt_saturated", 64'(corr_cnt), CNT_MAX);

        for (int p = 0; p < 10; p++) scrub_pass(NW'($urandom));

        // Asynchronous reset while a write-back is pending at address 2.
        load_mem(4'b0100, -1);
        expect_pass(4'b0100);
        pulse_start();
        n = 0;
        while (!(mem_wr && mem_addr == 2) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reached_wr_addr2", 64'(mem_wr && mem_addr == 2), 1);
        rst = 1'b1;
        #1;
        check_reset_vals();
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_after_reset", 64'(busy), 0);
        expect_pass(4'b0100);
        pulse_start();
        wait_idle();
        check("corr_cnt_after_rescan", 64'(corr_cnt), 1);

`ifdef SCRUB_ABORT_EN
        // Abort while waiting for read data at address 1; the late data must be ignored.
        rdy_mode = 0; rv_min = 3; rv_max = 3;
        load_mem(4'b0001, -1);
        rd_q.push_back(ADDR_W'(0));
        rd_q.push_back(ADDR_W'(1));
        wr_q.push_back('{a: ADDR_W'(0), d: orig[0]});
        pulse_start();
        n = 0;
        while (!(mem_addr == 1 && busy && !mem_rd && !mem_wr && !sec_r) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reached_rd_wait_addr1", 64'(mem_addr == 1 && !mem_rd), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 64'(busy), 0);
        check("abort_mem_rd", 64'(mem_rd), 0);
        check("abort_done", 64'(done), 0);
        check("abort_corr_cnt_held", 64'(corr_cnt), 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_stays_idle", 64'(busy | sec_r | mem_rd | mem_wr), 0);
        end
        check("abort_reads_seen", 64'(rd_q.size()), 0);
        check("abort_writes_seen", 64'(wr_q.size()), 0);
        rv_min = 0; rv_max = 2;
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
